pht_write_scheduler: RTL

// Schedules branch-resolution writes into the banked PHT RAM. Takes up to WRITE_NUM counter

---
 rtl/pht_write_scheduler_if.sv | 24 ++
 rtl/pht_write_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pht_write_scheduler_if.sv
// Update lanes from IntEx and write ports toward the banked PHT RAM.
// master drives requests and observes writes; slave is the scheduler.
interface pht_write_scheduler_if #(
    parameter int WRITE_NUM   = 2,
    parameter int IDX_W       = 11,
    parameter int ENTRY_WIDTH = 2
);
    logic [WRITE_NUM-1:0]                  req_valid;
    logic [WRITE_NUM-1:0][IDX_W-1:0]       req_index;
    logic [WRITE_NUM-1:0][ENTRY_WIDTH-1:0] req_value;
    logic [WRITE_NUM-1:0]                  wr_en;
    logic [WRITE_NUM-1:0][IDX_W-1:0]       wr_addr;
    logic [WRITE_NUM-1:0][ENTRY_WIDTH-1:0] wr_data;

    modport master (
        output req_valid, req_index, req_value,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_index, req_value,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pht_write_scheduler.sv
// Bank-conflict-free PHT write scheduler with deferral FIFO and init sweep.
// Optional PHT_WSCHED_STATS_EN adds the saturating drop_count output.
module pht_write_scheduler #(
    parameter int WRITE_NUM   = 2,
    parameter int ENTRY_NUM   = 2048,
    parameter int ENTRY_WIDTH = 2,
    parameter int BANK_NUM    = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_start,
    pht_write_scheduler_if.slave         bus,
    output logic                         init_busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef PHT_WSCHED_STATS_EN
    ,
    output logic [15:0]                  drop_count
`endif
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int PW    = $clog2(QUEUE_DEPTH);
    localparam int QW    = PW + 1;
    localparam int BW    = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int CW    = $clog2(WRITE_NUM + QUEUE_DEPTH + 1);
    localparam logic [ENTRY_WIDTH-1:0] WEAK = ENTRY_WIDTH'(1) << (ENTRY_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRY_NUM - WRITE_NUM);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                                state, state_nxt;
    logic [IDX_W-1:0]                      sweep, sweep_nxt;
    logic [QW-1:0]                         head, tail, count;
    logic [IDX_W-1:0]                      q_idx [QUEUE_DEPTH];
    logic [ENTRY_WIDTH-1:0]                q_val [QUEUE_DEPTH];
    logic [IDX_W-1:0]                      head_idx;
    logic [ENTRY_WIDTH-1:0]                head_val;
    logic [WRITE_NUM-1:0]                  en_nxt, grant, push_en;
    logic [WRITE_NUM-1:0][IDX_W-1:0]       addr_nxt;
    logic [WRITE_NUM-1:0][ENTRY_WIDTH-1:0] data_nxt;
    logic [WRITE_NUM-1:0][PW-1:0]          push_slot;
    logic [CW-1:0]                         push_num, drop_num, space;
    logic [(2**BW)-1:0]                    busy;
    logic                                  pop;
    logic                                  clash;

    function automatic logic [BW-1:0] bank_of(input logic [IDX_W-1:0] idx);
        return (BANK_NUM > 1) ? idx[BW-1:0] : '0;
    endfunction

    assign count       = tail - head;
    assign queue_count = count;
    assign head_idx    = q_idx[head[PW-1:0]];
    assign head_val    = q_val[head[PW-1:0]];

    // FSM state and sweep pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= sweep_nxt;
        end
    end

    // Next state: init_start restarts the sweep; the last group hands over to RUN.
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        if (init_start) begin
            state_nxt = ST_INIT;
            sweep_nxt = '0;
        end else if (state == ST_INIT) begin
            sweep_nxt = sweep + IDX_W'(WRITE_NUM);
            if (sweep == LAST) state_nxt = ST_RUN;
        end
    end

    // Outputs: sweep writes, or grants, head pop and FIFO pushes/drops.
    always_comb begin
        en_nxt    = '0;
        addr_nxt  = '0;
        data_nxt  = '0;
        grant     = '0;
        busy      = '0;
        pop       = 1'b0;
        push_en   = '0;
        push_slot = '0;
        push_num  = '0;
        drop_num  = '0;
        space     = CW'(QUEUE_DEPTH) - CW'(count);
        if (!init_start) begin
            if (state == ST_INIT) begin
                for (int i = 0; i < WRITE_NUM; i++) begin
                    en_nxt[i]   = 1'b1;
                    addr_nxt[i] = sweep + IDX_W'(i);
                    data_nxt[i] = WEAK;
                end
            end else begin
                for (int i = 0; i < WRITE_NUM; i++) begin
                    if (bus.req_valid[i] && !busy[bank_of(bus.req_index[i])]) begin
                        grant[i]    = 1'b1;
                        busy[bank_of(bus.req_index[i])] = 1'b1;
                        en_nxt[i]   = 1'b1;
                        addr_nxt[i] = bus.req_index[i];
                        data_nxt[i] = bus.req_value[i];
                    end
                end
                if (count != '0 && !busy[bank_of(head_idx)]) begin
                    for (int i = 0; i < WRITE_NUM; i++) begin
                        if (!pop && !en_nxt[i]) begin
                            pop         = 1'b1;
                            en_nxt[i]   = 1'b1;
                            addr_nxt[i] = head_idx;
                            data_nxt[i] = head_val;
                        end
                    end
                end
                if (pop) space = space + CW'(1);
                for (int i = 0; i < WRITE_NUM; i++) begin
                    if (bus.req_valid[i] && !grant[i]) begin
                        if (push_num < space) begin
                            push_en[i]   = 1'b1;
                            push_slot[i] = tail[PW-1:0] + PW'(push_num);
                            push_num     = push_num + CW'(1);
                        end else begin
                            drop_num = drop_num + CW'(1);
                        end
                    end
                end
            end
        end
    end

    // Registered write ports, busy flag and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.wr_en   <= '0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            init_busy   <= 1'b1;
            head        <= '0;
            tail        <= '0;
        end else begin
            bus.wr_en   <= en_nxt;
            bus.wr_addr <= addr_nxt;
            bus.wr_data <= data_nxt;
            init_busy   <= init_start || (state == ST_INIT);
            if (init_start) begin
                head <= '0;
                tail <= '0;
            end else begin
                head <= head + QW'(pop);
                tail <= tail + QW'(push_num);
            end
        end
    end

    // FIFO storage; deferred lanes land in consecutive slots from tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WRITE_NUM; i++) begin
            if (push_en[i]) begin
                q_idx[push_slot[i]] <= bus.req_index[i];
                q_val[push_slot[i]] <= bus.req_value[i];
            end
        end
    end

`ifdef PHT_WSCHED_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_count} + 17'(drop_num);

    // Saturating tally of updates lost to a full FIFO; init_start leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) drop_count <= '0;
        else        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop_num;
`endif

    // Detect two enabled ports aimed at one bank.
    always_comb begin
        clash = 1'b0;
        for (int i = 0; i < WRITE_NUM; i++) begin
            for (int j = i + 1; j < WRITE_NUM; j++) begin
                if (bus.wr_en[i] && bus.wr_en[j] &&
                    bank_of(bus.wr_addr[i]) == bank_of(bus.wr_addr[j]))
                    clash = 1'b1;
            end
        end
    end

    a_no_bank_clash: assert property (@(posedge clk) disable iff (!rst_n) !clash);

endmodule
